// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and types for the MDR display-path binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    localparam int IVW  = 16;
    localparam int NDIG = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the next shift.
module bcd_add3
    import bin_to_bcd_seq_pkg::*;
(
    input  bcd_digit_t i_Digit,
    output bcd_digit_t o_Digit
);

    assign o_Digit = (i_Digit >= 4'd5) ? bcd_digit_t'(i_Digit + 4'd3) : i_Digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock, with
// registered sign and leading-zero blank mask for the seven-segment decoders.
module bin_to_bcd_seq #(
    parameter int DW   = bin_to_bcd_seq_pkg::IVW,
    parameter int NDIG = bin_to_bcd_seq_pkg::NDIG
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_Start,
    input  logic [DW-1:0]     i_Val,
    input  logic              i_Signo,
    output logic              o_Busy,
    output logic              o_Done,
    output logic [4*NDIG-1:0] o_Bcd,
    output logic              o_Signo,
    output logic [NDIG-1:0]   o_Blank
);

    import bin_to_bcd_seq_pkg::*;

    localparam int CW = $clog2(DW + 1);

    bcd_state_t        r_state;
    logic [DW-1:0]     r_sr;
    logic [4*NDIG-1:0] r_acc;
    logic [CW-1:0]     r_cnt;
    logic              r_sgn;
    logic              r_busy;
    logic              r_done;
    logic [4*NDIG-1:0] r_bcd;
    logic              r_signo;
    logic [NDIG-1:0]   r_blank;

    logic [4*NDIG-1:0] w_acc_corr;
    logic [NDIG-1:0]   w_mask;
    logic              w_zero;

    for (genvar g = 0; g < NDIG; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_Digit(r_acc[4*g +: 4]),
            .o_Digit(w_acc_corr[4*g +: 4])
        );
    end

    // Digit 0 is never blanked so a zero result still shows "0".
    always_comb begin
        w_mask = '0;
        w_zero = 1'b1;
        for (int k = NDIG - 1; k >= 1; k--) begin
            w_zero    = w_zero & (r_acc[4*k +: 4] == 4'd0);
            w_mask[k] = w_zero;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sgn   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= '0;
            r_signo <= 1'b1;
            r_blank <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_Start) begin
                        r_sr    <= i_Val;
                        r_sgn   <= i_Signo;
                        r_acc   <= '0;
                        r_cnt   <= CW'(DW);
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Corrected digits shift left while the next magnitude bit enters the units digit.
                    r_acc <= {w_acc_corr[4*NDIG-2:0], r_sr[DW-1]};
                    r_sr  <= {r_sr[DW-2:0], 1'b0};
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_bcd   <= r_acc;
                    r_signo <= r_sgn;
                    r_blank <= w_mask;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_Busy  = r_busy;
    assign o_Done  = r_done;
    assign o_Bcd   = r_bcd;
    assign o_Signo = r_signo;
    assign o_Blank = r_blank;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq with a result scoreboard checked on each o_Done.
module tb_bin_to_bcd_seq;

    localparam int DW   = 16;
    localparam int NDIG = 5;

    typedef struct {
        logic [4*NDIG-1:0] bcd;
        logic [NDIG-1:0]   blank;
        logic              signo;
    } exp_t;

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_Start;
    logic [DW-1:0]     i_Val;
    logic              i_Signo;
    logic              o_Busy;
    logic              o_Done;
    logic [4*NDIG-1:0] o_Bcd;
    logic              o_Signo;
    logic [NDIG-1:0]   o_Blank;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bin_to_bcd_seq #(.DW(DW), .NDIG(NDIG)) dut (
        .i_clk  (clk),
        .i_rst  (i_rst),
        .i_Start(i_Start),
        .i_Val  (i_Val),
        .i_Signo(i_Signo),
        .o_Busy (o_Busy),
        .o_Done (o_Done),
        .o_Bcd  (o_Bcd),
        .o_Signo(o_Signo),
        .o_Blank(o_Blank)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int v, input logic s);
        exp_t e;
        int   x;
        bit   z;
        x = v;
        e.bcd = '0;
        for (int k = 0; k < NDIG; k++) begin
            e.bcd[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        e.blank = '0;
        z = 1'b1;
        for (int k = NDIG - 1; k >= 1; k--) begin
            z = z & (e.bcd[4*k +: 4] == 4'd0);
            e.blank[k] = z;
        end
        e.signo = s;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_conv(input logic [DW-1:0] v, input logic s);
        i_Val   = v;
        i_Signo = s;
        i_Start = 1'b1;
        sb.push_back(model(int'(v), s));
        tick();
        i_Start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int busy_cyc, output int lat, output bit seen);
        busy_cyc = 0;
        lat      = 0;
        seen     = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (o_Busy) busy_cyc++;
            tick();
            if (o_Done) begin
                seen = 1'b1;
                lat  = i + 1;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_bcd"}, 32'(o_Bcd), 32'(e.bcd));
            check({tag, "_blank"}, 32'(o_Blank), 32'(e.blank));
            check({tag, "_signo"}, 32'(o_Signo), 32'(e.signo));
        end
    endtask

    task automatic count_dones(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (o_Done) c++;
        end
    endtask

    task automatic run_one(input string tag, input logic [DW-1:0] v, input logic s, input logic [31:0] exp_bcd);
        int busy_cyc, lat, dones;
        bit seen;
        start_conv(v, s);
        wait_done(40, busy_cyc, lat, seen);
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(DW + 1));
        check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(DW + 1));
        check({tag, "_bcd_const"}, 32'(o_Bcd), exp_bcd);
        check_result(tag);
        tick();
        check({tag, "_done_pulse"}, 32'(o_Done), 32'd0);
        check({tag, "_busy_after"}, 32'(o_Busy), 32'd0);
        check({tag, "_hold"}, 32'(o_Bcd), exp_bcd);
        count_dones(3, dones);
        check({tag, "_no_extra_done"}, 32'(dones), 32'd0);
    endtask

    initial begin
        int busy_cyc, lat, dones, gap;
        bit seen;
        exp_t e;

        i_rst   = 1'b1;
        i_Start = 1'b0;
        i_Val   = '0;
        i_Signo = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        tick();
        check("rst_busy", 32'(o_Busy), 32'd0);
        check("rst_done", 32'(o_Done), 32'd0);
        check("rst_bcd", 32'(o_Bcd), 32'h00000);
        check("rst_blank", 32'(o_Blank), 32'd0);
        check("rst_signo", 32'(o_Signo), 32'd1);

        run_one("v255", 16'd255, 1'b1, 32'h00255);
        check("v255_blank_const", 32'(o_Blank), 32'b11000);
        run_one("v65535", 16'd65535, 1'b0, 32'h65535);
        check("v65535_blank_const", 32'(o_Blank), 32'b00000);
        run_one("v0", 16'd0, 1'b1, 32'h00000);
        check("v0_blank_const", 32'(o_Blank), 32'b11110);
        run_one("v32768", 16'd32768, 1'b0, 32'h32768);
        run_one("v100", 16'd100, 1'b1, 32'h00100);

        // Second request while busy must be ignored; only 1234 is expected.
        start_conv(16'd1234, 1'b0);
        repeat (4) tick();
        check("ign_busy", 32'(o_Busy), 32'd1);
        i_Val   = 16'd9;
        i_Signo = 1'b1;
        i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        wait_done(40, busy_cyc, lat, seen);
        check("ign_done_seen", 32'(seen), 32'd1);
        check("ign_latency", 32'(lat + 5), 32'(DW + 1));
        check_result("ign");
        count_dones(25, dones);
        check("ign_single_done", 32'(dones), 32'd0);

        // Reset mid-conversion aborts and restores reset values.
        start_conv(16'd4321, 1'b0);
        void'(sb.pop_back());
        repeat (7) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("abort_busy", 32'(o_Busy), 32'd0);
        check("abort_done", 32'(o_Done), 32'd0);
        check("abort_bcd", 32'(o_Bcd), 32'h00000);
        check("abort_blank", 32'(o_Blank), 32'd0);
        check("abort_signo", 32'(o_Signo), 32'd1);
        count_dones(25, dones);
        check("abort_no_done", 32'(dones), 32'd0);
        run_one("v42", 16'd42, 1'b1, 32'h00042);

        // Start held high: the cycle after DONE is not accepted, the next one is.
        i_Val   = 16'd789;
        i_Signo = 1'b0;
        i_Start = 1'b1;
        e = model(789, 1'b0);
        sb.push_back(e);
        sb.push_back(e);
        tick();
        wait_done(40, busy_cyc, lat, seen);
        check("b2b_first_seen", 32'(seen), 32'd1);
        check("b2b_first_lat", 32'(lat), 32'(DW + 1));
        check_result("b2b_first");
        wait_done(40, busy_cyc, gap, seen);
        i_Start = 1'b0;
        check("b2b_second_seen", 32'(seen), 32'd1);
        check("b2b_gap", 32'(gap), 32'(DW + 2));
        check_result("b2b_second");
        count_dones(25, dones);
        check("b2b_tail", 32'(dones), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
